// File: rtl/axi_mem_pkg.sv
// Shared definitions for the AXI burst memory model.
//   - AXI burst type encodings and the OKAY response code
//   - write-channel and read-channel FSM state enums
package axi_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

endpackage

// File: rtl/axi_mem_burst_addr.sv
// Next-word-index calculation for one AXI channel.
// Ports:
//   idx_i      current word index
//   burst_i    AXI burst type
//   next_idx_o index of the following beat; wraps modulo 2**idx_width_p
//              (the memory depth), which falls out of the fixed width.
module axi_mem_burst_addr
    import axi_mem_pkg::*;
#(
    parameter int idx_width_p = 10
) (
    input  logic [idx_width_p-1:0] idx_i,
    input  logic [1:0]             burst_i,
    output logic [idx_width_p-1:0] next_idx_o
);

    always_comb begin
        next_idx_o = idx_i + idx_width_p'(1);
        case (burst_i)
            BURST_FIXED: next_idx_o = idx_i;
            // WRAP is deliberately treated as plain incrementing.
            BURST_INCR, BURST_WRAP: next_idx_o = idx_i + idx_width_p'(1);
            default:     next_idx_o = idx_i + idx_width_p'(1);
        endcase
    end

endmodule

// File: rtl/axi_burst_mem_model.sv
// Behavioural AXI3-style burst memory slave: one write burst and one read
// burst in flight concurrently on independent channels.
// Optional build macro: AXI_MEM_TRACE_EN prints one line per accepted W beat
// and per accepted R beat; without it the model is silent.
// Ports:
//   clk_i / reset_i                 clock, synchronous active-high reset
//   axi_aw* / axi_w* / axi_b*       write address, data, response channels
//   axi_ar* / axi_r*                read address and data channels
// Memory contents survive reset; they start at init_data_p.
module axi_burst_mem_model
    import axi_mem_pkg::*;
#(
    parameter int axi_id_width_p   = 6,
    parameter int axi_addr_width_p = 32,
    parameter int axi_data_width_p = 64,
    parameter int axi_len_width_p  = 4,
    parameter int mem_els_p        = 1024,
    parameter logic [axi_data_width_p-1:0] init_data_p = '0
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [axi_id_width_p-1:0]     axi_awid_i,
    input  logic [axi_addr_width_p-1:0]   axi_awaddr_i,
    input  logic [axi_len_width_p-1:0]    axi_awlen_i,
    input  logic [1:0]                    axi_awburst_i,
    input  logic                          axi_awvalid_i,
    output logic                          axi_awready_o,
    input  logic [axi_data_width_p-1:0]   axi_wdata_i,
    input  logic [axi_data_width_p/8-1:0] axi_wstrb_i,
    input  logic                          axi_wlast_i,
    input  logic                          axi_wvalid_i,
    output logic                          axi_wready_o,
    output logic [axi_id_width_p-1:0]     axi_bid_o,
    output logic [1:0]                    axi_bresp_o,
    output logic                          axi_bvalid_o,
    input  logic                          axi_bready_i,
    input  logic [axi_id_width_p-1:0]     axi_arid_i,
    input  logic [axi_addr_width_p-1:0]   axi_araddr_i,
    input  logic [axi_len_width_p-1:0]    axi_arlen_i,
    input  logic [1:0]                    axi_arburst_i,
    input  logic                          axi_arvalid_i,
    output logic                          axi_arready_o,
    output logic [axi_id_width_p-1:0]     axi_rid_o,
    output logic [axi_data_width_p-1:0]   axi_rdata_o,
    output logic [1:0]                    axi_rresp_o,
    output logic                          axi_rlast_o,
    output logic                          axi_rvalid_o,
    input  logic                          axi_rready_i
);

    localparam int STRB_W = axi_data_width_p / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(mem_els_p);

    logic [axi_data_width_p-1:0] r_mem [mem_els_p] = '{default: init_data_p};

    // Write channel state
    w_state_e                r_wstate;
    logic [axi_id_width_p-1:0] r_awid;
    logic [IDX_W-1:0]        r_widx;
    logic [1:0]              r_wburst;
    logic                    r_awready, r_wready, r_bvalid;

    // Read channel state
    r_state_e                r_rstate;
    logic [axi_id_width_p-1:0] r_arid;
    logic [IDX_W-1:0]        r_ridx;
    logic [1:0]              r_rburst;
    logic [axi_len_width_p-1:0] r_rlen, r_rcnt;
    logic                    r_arready, r_rvalid;

    logic [IDX_W-1:0]        w_awidx, w_aridx, w_wnext, w_rnext;
    logic                    w_wfire, w_rfire, w_rlast;
    logic                    w_unused;

    // Byte offset bits are dropped; the upper address bits fold away by width.
    assign w_awidx = axi_awaddr_i[OFF_W +: IDX_W];
    assign w_aridx = axi_araddr_i[OFF_W +: IDX_W];
    // Bursts end on wlast, so awlen plays no part in the write path.
    assign w_unused = ^{axi_awlen_i, axi_awaddr_i, axi_araddr_i};

    axi_mem_burst_addr #(.idx_width_p(IDX_W)) u_waddr (
        .idx_i(r_widx), .burst_i(r_wburst), .next_idx_o(w_wnext));
    axi_mem_burst_addr #(.idx_width_p(IDX_W)) u_raddr (
        .idx_i(r_ridx), .burst_i(r_rburst), .next_idx_o(w_rnext));

    assign w_wfire = !reset_i && r_wready && axi_wvalid_i;
    assign w_rfire = !reset_i && r_rvalid && axi_rready_i;
    assign w_rlast = r_rvalid && (r_rcnt == r_rlen);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_awid    <= '0;
            r_widx    <= '0;
            r_wburst  <= BURST_INCR;
        end else begin
            case (r_wstate)
                W_IDLE: if (axi_awvalid_i) begin
                    r_awid    <= axi_awid_i;
                    r_widx    <= w_awidx;
                    r_wburst  <= axi_awburst_i;
                    r_awready <= 1'b0;
                    r_wready  <= 1'b1;
                    r_wstate  <= W_DATA;
                end
                W_DATA: if (axi_wvalid_i) begin
                    r_widx <= w_wnext;
                    if (axi_wlast_i) begin
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: if (axi_bready_i) begin
                    r_bvalid  <= 1'b0;
                    r_awready <= 1'b1;
                    r_wstate  <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Byte-masked write; reads see the new data only from the next cycle.
    always_ff @(posedge clk_i) begin
        if (w_wfire) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_wstrb_i[b]) r_mem[r_widx][b*8 +: 8] <= axi_wdata_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_arid    <= '0;
            r_ridx    <= '0;
            r_rburst  <= BURST_INCR;
            r_rlen    <= '0;
            r_rcnt    <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: if (axi_arvalid_i) begin
                    r_arid    <= axi_arid_i;
                    r_ridx    <= w_aridx;
                    r_rburst  <= axi_arburst_i;
                    r_rlen    <= axi_arlen_i;
                    r_rcnt    <= '0;
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b1;
                    r_rstate  <= R_DATA;
                end
                R_DATA: if (axi_rready_i) begin
                    r_rcnt <= r_rcnt + axi_len_width_p'(1);
                    r_ridx <= w_rnext;
                    if (w_rlast) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

`ifdef AXI_MEM_TRACE_EN
    always_ff @(posedge clk_i) begin
        if (w_wfire) $display("%0t axi_mem W idx=%0d data=%h strb=%h", $time, r_widx, axi_wdata_i, axi_wstrb_i);
        if (w_rfire) $display("%0t axi_mem R idx=%0d data=%h", $time, r_ridx, axi_rdata_o);
    end
`endif

    assign axi_awready_o = r_awready;
    assign axi_wready_o  = r_wready;
    assign axi_bvalid_o  = r_bvalid;
    assign axi_bid_o     = r_awid;
    assign axi_bresp_o   = RESP_OKAY;
    assign axi_arready_o = r_arready;
    assign axi_rvalid_o  = r_rvalid;
    assign axi_rid_o     = r_arid;
    assign axi_rdata_o   = r_mem[r_ridx];  // combinational read of the current beat
    assign axi_rresp_o   = RESP_OKAY;
    assign axi_rlast_o   = w_rlast;

endmodule

// File: tb/tb_axi_burst_mem_model.sv
// Directed self-checking bench for axi_burst_mem_model (64-bit data, 1024 words).
module tb_axi_burst_mem_model;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [5:0]  awid = '0, arid = '0, bid, rid;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [3:0]  awlen = '0, arlen = '0;
    logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
    logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready;
    logic        bvalid, bready = 0, arvalid = 0, arready, rlast, rvalid, rready = 0;
    logic [63:0] wdata = '0, rdata;
    logic [7:0]  wstrb = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    axi_burst_mem_model dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen),
        .axi_awburst_i(awburst), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
        .axi_wvalid_i(wvalid), .axi_wready_o(wready),
        .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen),
        .axi_arburst_i(arburst), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp),
        .axi_rlast_o(rlast), .axi_rvalid_o(rvalid), .axi_rready_i(rready)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Write burst with a common strobe; checks B response and return to idle.
    task automatic wr(input logic [31:0] a, input logic [3:0] len, input logic [1:0] bt,
                      input logic [5:0] id, input logic [3:0][63:0] d, input logic [7:0] st);
        awaddr = a; awlen = len; awburst = bt; awid = id; awvalid = 1;
        step();
        awvalid = 0;
        n_cmp++; if (wready !== 1'b1) begin n_bad++; $display("FAIL wr_wready: got %b want 1", wready); end
        for (int i = 0; i <= int'(len); i++) begin
            wdata = d[i]; wstrb = st; wlast = (i == int'(len)); wvalid = 1;
            step();
        end
        wvalid = 0; wlast = 0;
        n_cmp++; if (bvalid !== 1'b1) begin n_bad++; $display("FAIL wr_bvalid: got %b want 1", bvalid); end
        n_cmp++; if (bid !== id) begin n_bad++; $display("FAIL wr_bid: got %0d want %0d", bid, id); end
        n_cmp++; if (bresp !== 2'b00) begin n_bad++; $display("FAIL wr_bresp: got %b want 00", bresp); end
        n_cmp++; if (awready !== 1'b0) begin n_bad++; $display("FAIL wr_aw_blocked: got %b want 0", awready); end
        bready = 1;
        step();
        bready = 0;
        n_cmp++; if (bvalid !== 1'b0 || awready !== 1'b1) begin
            n_bad++; $display("FAIL wr_b_done: got bvalid=%b awready=%b want 0/1", bvalid, awready);
        end
    endtask

    // Read burst with rready held high; checks latency, data, rlast and rid.
    task automatic rd(input logic [31:0] a, input logic [3:0] len, input logic [1:0] bt,
                      input logic [5:0] id, input logic [3:0][63:0] e);
        araddr = a; arlen = len; arburst = bt; arid = id; arvalid = 1; rready = 1;
        step();
        arvalid = 0;
        for (int k = 0; k <= int'(len); k++) begin
            n_cmp++; if (rvalid !== 1'b1) begin n_bad++; $display("FAIL rd_rvalid[%0d]: got %b want 1", k, rvalid); end
            n_cmp++; if (rdata !== e[k]) begin n_bad++; $display("FAIL rd_rdata[%0d]: got %h want %h", k, rdata, e[k]); end
            n_cmp++; if (rlast !== (k == int'(len))) begin n_bad++; $display("FAIL rd_rlast[%0d]: got %b want %b", k, rlast, k == int'(len)); end
            n_cmp++; if (rid !== id || rresp !== 2'b00) begin n_bad++; $display("FAIL rd_rid[%0d]: got %0d/%b want %0d/00", k, rid, rresp, id); end
            step();
        end
        rready = 0;
        n_cmp++; if (rvalid !== 1'b0 || arready !== 1'b1) begin
            n_bad++; $display("FAIL rd_done: got rvalid=%b arready=%b want 0/1", rvalid, arready);
        end
    endtask

    task automatic test_reset();
        reset_i = 1;
        step(); step();
        n_cmp++; if (awready !== 1'b1) begin n_bad++; $display("FAIL rst_awready: got %b want 1", awready); end
        n_cmp++; if (arready !== 1'b1) begin n_bad++; $display("FAIL rst_arready: got %b want 1", arready); end
        n_cmp++; if (wready !== 1'b0) begin n_bad++; $display("FAIL rst_wready: got %b want 0", wready); end
        n_cmp++; if (bvalid !== 1'b0) begin n_bad++; $display("FAIL rst_bvalid: got %b want 0", bvalid); end
        n_cmp++; if (rvalid !== 1'b0 || rlast !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %b/%b want 0/0", rvalid, rlast); end
        n_cmp++; if (bresp !== 2'b00 || rresp !== 2'b00) begin n_bad++; $display("FAIL rst_resp: got %b/%b want 00/00", bresp, rresp); end
        reset_i = 0;
        step();
    endtask

    task automatic test_incr();
        wr(32'h40, 4'd3, 2'b01, 6'd5, {64'd4, 64'd3, 64'd2, 64'd1}, 8'hFF);
        rd(32'h40, 4'd3, 2'b01, 6'd9, {64'd4, 64'd3, 64'd2, 64'd1});
    endtask

    task automatic test_fixed();
        wr(32'h80, 4'd2, 2'b00, 6'd7, {64'd0, 64'hC, 64'hB, 64'hA}, 8'hFF);
        rd(32'h80, 4'd1, 2'b01, 6'd2, {64'd0, 64'd0, 64'd0, 64'hC});
    endtask

    task automatic test_strobe();
        wr(32'hA0, 4'd0, 2'b01, 6'd1, {192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 8'hFF);
        wr(32'hA0, 4'd0, 2'b01, 6'd2, {192'd0, 64'h1122_3344_5566_7788}, 8'h0F);
        rd(32'hA0, 4'd0, 2'b01, 6'd3, {192'd0, 64'hFFFF_FFFF_5566_7788});
    endtask

    task automatic test_stall();
        logic [11:0] pat;
        int k;
        pat = 12'b1111_1111_1001;  // rready per cycle: 1,0,0,1,1,...
        k = 0;
        araddr = 32'h40; arlen = 4'd3; arburst = 2'b01; arid = 6'd3; arvalid = 1; rready = 0;
        step();
        arvalid = 0;
        for (int c = 0; c < 12 && k <= 3; c++) begin
            n_cmp++; if (rvalid !== 1'b1 || rdata !== 64'(k + 1)) begin
                n_bad++; $display("FAIL stall_data[c%0d]: got v=%b d=%h want 1/%h", c, rvalid, rdata, 64'(k + 1));
            end
            n_cmp++; if (rlast !== (k == 3)) begin n_bad++; $display("FAIL stall_rlast[c%0d]: got %b want %b", c, rlast, k == 3); end
            rready = pat[c];
            step();
            if (pat[c]) k++;
        end
        rready = 0;
        n_cmp++; if (k != 4 || rvalid !== 1'b0) begin n_bad++; $display("FAIL stall_end: got beats=%0d rvalid=%b want 4/0", k, rvalid); end
    endtask

    task automatic test_wrap_and_reset();
        wr(32'h1FF8, 4'd1, 2'b01, 6'd4, {64'd0, 64'd0, 64'hBBBB, 64'hAAAA}, 8'hFF);
        rd(32'h1FF8, 4'd1, 2'b01, 6'd7, {64'd0, 64'd0, 64'hBBBB, 64'hAAAA});
        // Abandon a read burst with reset after one beat.
        araddr = 32'h40; arlen = 4'd3; arburst = 2'b01; arid = 6'd6; arvalid = 1; rready = 1;
        step();
        arvalid = 0;
        step();
        n_cmp++; if (rdata !== 64'd2) begin n_bad++; $display("FAIL midrd_beat1: got %h want 2", rdata); end
        reset_i = 1;
        step();
        n_cmp++; if (rvalid !== 1'b0 || arready !== 1'b1 || rlast !== 1'b0) begin
            n_bad++; $display("FAIL midrd_reset: got v=%b ar=%b l=%b want 0/1/0", rvalid, arready, rlast);
        end
        reset_i = 0; rready = 0;
        step();
        rd(32'h40, 4'd3, 2'b01, 6'd8, {64'd4, 64'd3, 64'd2, 64'd1});
    endtask

    initial begin
        test_reset();
        test_incr();
        test_fixed();
        test_strobe();
        test_stall();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
